// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Recovers a HH:MM time value from a multiplexed 4-digit 7-segment display by
// watching the anode scan and sampling the segment bus once per digit dwell.
// When all four digit slots have been sampled, the frame is checked (valid
// glyphs, minutes < 60, hours < 24) and either published on dakika/saat with
// a frame_valid pulse, or dropped with a frame_error pulse.
//
// Optional feature (macro SEG_DECODER_CONFIRM_EN): a passing frame is only
// published when it matches the immediately preceding passing frame; the
// first occurrence is held as a candidate without any pulse.
//
// Parameters:
//   SETTLE_CYCLES  - cycles an anode code must stay unchanged before the
//                    segment bus is sampled (1..255)
//   SEG_ACTIVE_LOW - 1: segment inputs are inverted before decoding
//
// Ports:
//   clk         in   clock, all state changes on rising edge
//   reset       in   synchronous, active-low reset
//   segment     in   [6:0] scanned segment bus, gfedcba
//   sayac       in   [3:0] active-low one-hot anodes
//                    (bit0 min units, bit1 min tens, bit2 hour units,
//                     bit3 hour tens)
//   dakika      out  [5:0] last accepted minutes
//   saat        out  [5:0] last accepted hours
//   frame_valid out  one-cycle pulse when dakika/saat update
//   frame_error out  one-cycle pulse when a completed frame is rejected
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segment,
    input  logic [3:0] sayac,
    output logic [5:0] dakika,
    output logic [5:0] saat,
    output logic       frame_valid,
    output logic       frame_error
);

    localparam logic [7:0] SETTLE_L = 8'(SETTLE_CYCLES);

    // Returns {invalid, digit}; unknown glyphs yield invalid=1, digit=0.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h3F:   res = 5'h00;
            7'h06:   res = 5'h01;
            7'h5B:   res = 5'h02;
            7'h4F:   res = 5'h03;
            7'h66:   res = 5'h04;
            7'h6D:   res = 5'h05;
            7'h7D:   res = 5'h06;
            7'h07:   res = 5'h07;
            7'h7F:   res = 5'h08;
            7'h6F:   res = 5'h09;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

    // Returns {legal, slot}; legal only when exactly one anode is driven.
    function automatic logic [2:0] anode_decode(input logic [3:0] an);
        logic [2:0] res;
        case (an)
            4'hE:    res = 3'b100;
            4'hD:    res = 3'b101;
            4'hB:    res = 3'b110;
            4'h7:    res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    logic [3:0]       prev_sayac_r;
    logic [7:0]       cnt_r;
    logic [7:0]       cnt_nxt_s;
    logic             sample_s;
    logic [2:0]       anode_s;
    logic [6:0]       seg_act_s;
    logic [4:0]       dec_s;
    logic [3:0]       slot_oh_s;
    logic [3:0]       seen_r;
    logic [3:0][3:0]  digit_r;
    logic [3:0]       inv_r;
    logic             done_r;
    logic [6:0]       mins_s;
    logic [6:0]       hrs_s;
    logic             pass_s;
`ifdef SEG_DECODER_CONFIRM_EN
    logic             cand_v_r;
    logic [5:0]       cand_min_r;
    logic [5:0]       cand_hr_r;
`endif

    // Input conditioning: segment polarity, glyph decode, anode slot decode.
    always_comb begin
        seg_act_s = segment;
        if (SEG_ACTIVE_LOW) begin
            seg_act_s = ~segment;
        end else begin
            seg_act_s = segment;
        end
        dec_s     = seg_decode(seg_act_s);
        anode_s   = anode_decode(sayac);
        slot_oh_s = 4'b0001 << anode_s[1:0];
    end

    // Stability counter next value; saturates at SETTLE so a dwell samples once.
    always_comb begin
        cnt_nxt_s = 8'd0;
        sample_s  = 1'b0;
        if (anode_s[2] && (sayac == prev_sayac_r)) begin
            if (cnt_r < SETTLE_L) begin
                cnt_nxt_s = cnt_r + 8'd1;
            end else begin
                cnt_nxt_s = cnt_r;
            end
            sample_s = (cnt_r == (SETTLE_L - 8'd1));
        end else begin
            cnt_nxt_s = 8'd0;
            sample_s  = 1'b0;
        end
    end

    // Anode history and stability counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_sayac_r <= 4'hF;
            cnt_r        <= 8'd0;
        end else begin
            prev_sayac_r <= sayac;
            cnt_r        <= cnt_nxt_s;
        end
    end

    // Digit slots, seen bits and frame-complete strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seen_r  <= 4'h0;
            digit_r <= '0;
            inv_r   <= 4'h0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (sample_s) begin
                digit_r[anode_s[1:0]] <= dec_s[3:0];
                inv_r[anode_s[1:0]]   <= dec_s[4];
                if ((seen_r | slot_oh_s) == 4'hF) begin
                    seen_r <= 4'h0;
                    done_r <= 1'b1;
                end else begin
                    seen_r <= seen_r | slot_oh_s;
                end
            end
        end
    end

    // Frame check on the slots captured by the completing sample; 7-bit math
    // so that e.g. 99 is rejected rather than wrapped.
    always_comb begin
        mins_s = ({3'b000, digit_r[1]} * 7'd10) + {3'b000, digit_r[0]};
        hrs_s  = ({3'b000, digit_r[3]} * 7'd10) + {3'b000, digit_r[2]};
        pass_s = (inv_r == 4'h0) && (mins_s < 7'd60) && (hrs_s < 7'd24);
    end

    // Published time and result pulses, one cycle after frame completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dakika      <= 6'd0;
            saat        <= 6'd0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
`ifdef SEG_DECODER_CONFIRM_EN
            cand_v_r    <= 1'b0;
            cand_min_r  <= 6'd0;
            cand_hr_r   <= 6'd0;
`endif
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            if (done_r) begin
                if (pass_s) begin
`ifdef SEG_DECODER_CONFIRM_EN
                    if (cand_v_r && (cand_min_r == mins_s[5:0]) &&
                        (cand_hr_r == hrs_s[5:0])) begin
                        dakika      <= mins_s[5:0];
                        saat        <= hrs_s[5:0];
                        frame_valid <= 1'b1;
                    end
                    cand_v_r   <= 1'b1;
                    cand_min_r <= mins_s[5:0];
                    cand_hr_r  <= hrs_s[5:0];
`else
                    dakika      <= mins_s[5:0];
                    saat        <= hrs_s[5:0];
                    frame_valid <= 1'b1;
`endif
                end else begin
                    frame_error <= 1'b1;
`ifdef SEG_DECODER_CONFIRM_EN
                    cand_v_r    <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Self-checking bench for seg_scan_decoder. Stimulus is a sequence of anode
// dwells; a digit-level model (which slots were seen, which glyph each holds,
// HH:MM arithmetic) predicts how many frame_valid / frame_error pulses appear
// and which time is published. Honors SEG_DECODER_CONFIRM_EN if defined.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

    localparam int SETTLE = 4;
    localparam bit SEG_AL = 1'b0;
`ifdef SEG_DECODER_CONFIRM_EN
    localparam int REPS = 2;
`else
    localparam int REPS = 1;
`endif
    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] segment;
    logic [3:0] sayac;
    logic [5:0] dakika;
    logic [5:0] saat;
    logic       frame_valid;
    logic       frame_error;

    seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .SEG_ACTIVE_LOW(SEG_AL)) dut (
        .clk(clk), .reset(reset), .segment(segment), .sayac(sayac),
        .dakika(dakika), .saat(saat),
        .frame_valid(frame_valid), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int v_cnt = 0, e_cnt = 0, both_cnt = 0;

    // Pulse counters observed away from the active edge.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) v_cnt++;
        if (frame_error === 1'b1) e_cnt++;
        if (frame_valid === 1'b1 && frame_error === 1'b1) both_cnt++;
    end

    // Reference model state
    int m_dig[4];
    bit m_inv[4];
    bit m_seen[4];
    int exp_v = 0, exp_e = 0, exp_min = 0, exp_hr = 0;
    bit cand_v = 1'b0;
    int cand_min = 0, cand_hr = 0;

    function automatic int slot_of(input logic [3:0] a);
        case (a)
            4'hE: return 0;
            4'hD: return 1;
            4'hB: return 2;
            4'h7: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int glyph_value(input logic [6:0] p);
        for (int k = 0; k < 10; k++) if (SEG_TAB[k] == p) return k;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin m_dig[i] = 0; m_inv[i] = 0; m_seen[i] = 0; end
        exp_min = 0; exp_hr = 0; cand_v = 1'b0;
    endtask

    task automatic model_complete();
        int mins, hrs;
        bit ok;
        mins = m_dig[1] * 10 + m_dig[0];
        hrs  = m_dig[3] * 10 + m_dig[2];
        ok = !(m_inv[0] || m_inv[1] || m_inv[2] || m_inv[3]) && mins < 60 && hrs < 24;
`ifdef SEG_DECODER_CONFIRM_EN
        if (ok) begin
            if (cand_v && cand_min == mins && cand_hr == hrs) begin
                exp_min = mins; exp_hr = hrs; exp_v++;
            end
            cand_v = 1'b1; cand_min = mins; cand_hr = hrs;
        end else begin
            cand_v = 1'b0; exp_e++;
        end
`else
        if (ok) begin exp_min = mins; exp_hr = hrs; exp_v++; end
        else exp_e++;
`endif
    endtask

    task automatic model_sample(input int s, input logic [6:0] p);
        int g;
        g = glyph_value(p);
        m_dig[s] = (g < 0) ? 0 : g;
        m_inv[s] = (g < 0);
        m_seen[s] = 1'b1;
        if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
            for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
            model_complete();
        end
    endtask

    // Hold one anode code for 'dwell' rising edges; callers never repeat a code
    // back-to-back, so each call is a fresh dwell.
    task automatic apply(input logic [3:0] a, input logic [6:0] p, input int dwell);
        @(negedge clk);
        sayac = a;
        segment = SEG_AL ? ~p : p;
        repeat (dwell - 1) @(negedge clk);
        if (slot_of(a) >= 0 && dwell > SETTLE) model_sample(slot_of(a), p);
    endtask

    task automatic scan_pats(input logic [6:0] p0, p1, p2, p3, input int dwell);
        apply(4'hE, p0, dwell);
        apply(4'hD, p1, dwell);
        apply(4'hB, p2, dwell);
        apply(4'h7, p3, dwell);
        apply(4'hF, 7'h00, 4);
    endtask

    task automatic scan_time(input int hr, input int mn, input int dwell);
        scan_pats(SEG_TAB[mn % 10], SEG_TAB[mn / 10], SEG_TAB[hr % 10], SEG_TAB[hr / 10], dwell);
    endtask

    task automatic test_reset();
        reset = 1'b0; sayac = 4'hF; segment = 7'h00;
        repeat (3) @(negedge clk);
        n_chk++; if (dakika !== 6'd0) begin n_fail++; $display("FAIL reset_dakika: got %0d want 0", dakika); end
        n_chk++; if (saat !== 6'd0) begin n_fail++; $display("FAIL reset_saat: got %0d want 0", saat); end
        n_chk++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
        n_chk++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", frame_error); end
        model_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_scan_1234();
        int v0, e0;
        v0 = v_cnt; e0 = e_cnt;
        for (int r = 0; r < REPS; r++) scan_time(12, 34, 10);
        n_chk++; if (v_cnt - v0 !== 1) begin n_fail++; $display("FAIL s1234_valid: got %0d want 1", v_cnt - v0); end
        n_chk++; if (e_cnt - e0 !== 0) begin n_fail++; $display("FAIL s1234_error: got %0d want 0", e_cnt - e0); end
        n_chk++; if (saat !== 6'd12) begin n_fail++; $display("FAIL s1234_saat: got %0d want 12", saat); end
        n_chk++; if (dakika !== 6'd34) begin n_fail++; $display("FAIL s1234_dakika: got %0d want 34", dakika); end
    endtask

    task automatic test_range_reject();
        int v0, e0;
        v0 = v_cnt; e0 = e_cnt;
        scan_time(25, 0, 10);
        scan_time(99, 99, 10);
        n_chk++; if (e_cnt - e0 !== 2) begin n_fail++; $display("FAIL range_error: got %0d want 2", e_cnt - e0); end
        n_chk++; if (v_cnt - v0 !== 0) begin n_fail++; $display("FAIL range_valid: got %0d want 0", v_cnt - v0); end
        n_chk++; if (saat !== 6'd12 || dakika !== 6'd34) begin n_fail++; $display("FAIL range_hold: got %0d:%0d want 12:34", saat, dakika); end
    endtask

    task automatic test_invalid_glyph();
        int v0, e0;
        v0 = v_cnt; e0 = e_cnt;
        scan_pats(7'h00, SEG_TAB[5], SEG_TAB[3], SEG_TAB[2], 10);
        n_chk++; if (e_cnt - e0 !== 1) begin n_fail++; $display("FAIL glyph_error: got %0d want 1", e_cnt - e0); end
        for (int r = 0; r < REPS; r++) scan_time(23, 59, 12);
        n_chk++; if (v_cnt - v0 !== 1) begin n_fail++; $display("FAIL glyph_valid: got %0d want 1", v_cnt - v0); end
        n_chk++; if (saat !== 6'd23 || dakika !== 6'd59) begin n_fail++; $display("FAIL glyph_time: got %0d:%0d want 23:59", saat, dakika); end
    endtask

    task automatic test_short_dwell();
        int v0, e0;
        v0 = v_cnt; e0 = e_cnt;
        scan_time(11, 11, SETTLE - 1);
        apply(4'h0, SEG_TAB[1], 20);
        apply(4'h3, SEG_TAB[2], 20);
        apply(4'hF, SEG_TAB[3], 20);
        apply(4'h0, SEG_TAB[4], 20);
        n_chk++; if (v_cnt - v0 !== 0 || e_cnt - e0 !== 0) begin n_fail++; $display("FAIL short_pulses: got %0d/%0d want 0/0", v_cnt - v0, e_cnt - e0); end
        n_chk++; if (saat !== 6'd23 || dakika !== 6'd59) begin n_fail++; $display("FAIL short_hold: got %0d:%0d want 23:59", saat, dakika); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0;
        apply(4'hE, SEG_TAB[7], 10);
        apply(4'hD, SEG_TAB[4], 10);
        @(negedge clk); reset = 1'b0; sayac = 4'hF;
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b1;
        n_chk++; if (saat !== 6'd0 || dakika !== 6'd0) begin n_fail++; $display("FAIL rmid_cleared: got %0d:%0d want 0:0", saat, dakika); end
        v0 = v_cnt; e0 = e_cnt;
        apply(4'hB, SEG_TAB[8], 10);
        apply(4'h7, SEG_TAB[0], 10);
        apply(4'hF, 7'h00, 4);
        n_chk++; if (v_cnt - v0 !== 0 || e_cnt - e0 !== 0) begin n_fail++; $display("FAIL rmid_partial: got %0d/%0d want 0/0", v_cnt - v0, e_cnt - e0); end
        for (int r = 0; r < REPS; r++) scan_time(8, 15, 10);
        n_chk++; if (v_cnt - v0 !== 1) begin n_fail++; $display("FAIL rmid_valid: got %0d want 1", v_cnt - v0); end
        n_chk++; if (saat !== 6'd8 || dakika !== 6'd15) begin n_fail++; $display("FAIL rmid_time: got %0d:%0d want 8:15", saat, dakika); end
    endtask

`ifdef SEG_DECODER_CONFIRM_EN
    task automatic test_confirm();
        int v0;
        v0 = v_cnt;
        scan_time(10, 0, 10);
        scan_time(10, 1, 10);
        n_chk++; if (v_cnt - v0 !== 0) begin n_fail++; $display("FAIL confirm_early: got %0d want 0", v_cnt - v0); end
        scan_time(10, 1, 10);
        n_chk++; if (v_cnt - v0 !== 1) begin n_fail++; $display("FAIL confirm_valid: got %0d want 1", v_cnt - v0); end
        n_chk++; if (saat !== 6'd10 || dakika !== 6'd1) begin n_fail++; $display("FAIL confirm_time: got %0d:%0d want 10:1", saat, dakika); end
    endtask
`endif

    task automatic test_random_frames();
        int ord[4];
        int dig[4];
        int hr, mn, s, j, t, dwell;
        logic [3:0] an;
        logic [6:0] p;
        for (int f = 0; f < 30; f++) begin
            hr = $urandom_range(0, 29);
            mn = $urandom_range(0, 69);
            // occasionally replay the previous time so confirm mode publishes
            if ($urandom_range(0, 3) == 0) begin hr = exp_hr; mn = exp_min; end
            dig[0] = mn % 10; dig[1] = mn / 10; dig[2] = hr % 10; dig[3] = hr / 10;
            for (int i = 0; i < 4; i++) ord[i] = i;
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i); t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            for (int i = 0; i < 4; i++) begin
                s = ord[i];
                an = 4'hF; an[s] = 1'b0;
                p = SEG_TAB[dig[s]];
                if ($urandom_range(0, 9) == 0) p = 7'($urandom);
                if ($urandom_range(0, 7) == 0) dwell = $urandom_range(1, SETTLE - 1);
                else dwell = $urandom_range(SETTLE + 1, SETTLE + 8);
                apply(an, p, dwell);
            end
            apply(4'hF, 7'h00, 4);
            n_chk++; if (v_cnt !== exp_v || e_cnt !== exp_e) begin n_fail++; $display("FAIL rand_pulses f%0d: got %0d/%0d want %0d/%0d", f, v_cnt, e_cnt, exp_v, exp_e); end
            n_chk++; if (saat !== 6'(exp_hr) || dakika !== 6'(exp_min)) begin n_fail++; $display("FAIL rand_time f%0d: got %0d:%0d want %0d:%0d", f, saat, dakika, exp_hr, exp_min); end
        end
        n_chk++; if (both_cnt !== 0) begin n_fail++; $display("FAIL exclusive: got %0d overlapping cycles want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        exp_v = v_cnt; exp_e = e_cnt;
        test_scan_1234();
        test_range_reject();
        test_invalid_glyph();
        test_short_dwell();
        test_reset_mid_frame();
`ifdef SEG_DECODER_CONFIRM_EN
        test_confirm();
`endif
        exp_v = v_cnt; exp_e = e_cnt;
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
